// File: rtl/fma_operand_unpack.sv
// FMA operand unpack: two-stage valid/ready pipeline decoding A + B*C operands.
// Optional macro FMA_UNPACK_DAZ_EN treats subnormal inputs as signed zero.
module fma_operand_unpack #(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_RM   = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         Valid_i,
    output logic                         Ready_o,
    input  logic [PARM_EXP+PARM_MANT:0]  A_i,
    input  logic [PARM_EXP+PARM_MANT:0]  B_i,
    input  logic [PARM_EXP+PARM_MANT:0]  C_i,
    input  logic [PARM_RM-1:0]           Rounding_mode_i,
    output logic                         Valid_o,
    input  logic                         Ready_i,
    output logic                         A_Sign_o,
    output logic [PARM_EXP-1:0]          A_Exp_raw_o,
    output logic [PARM_MANT:0]           A_Mant_o,
    output logic                         A_DeN_o,
    output logic                         A_Inf_o,
    output logic                         A_Zero_o,
    output logic                         A_NaN_o,
    output logic                         B_Sign_o,
    output logic [PARM_EXP-1:0]          B_Exp_raw_o,
    output logic [PARM_MANT:0]           B_Mant_o,
    output logic                         B_DeN_o,
    output logic                         B_Inf_o,
    output logic                         B_Zero_o,
    output logic                         B_NaN_o,
    output logic                         C_Sign_o,
    output logic [PARM_EXP-1:0]          C_Exp_raw_o,
    output logic [PARM_MANT:0]           C_Mant_o,
    output logic                         C_DeN_o,
    output logic                         C_Inf_o,
    output logic                         C_Zero_o,
    output logic                         C_NaN_o,
    output logic                         Sub_Sign_o,
    output logic [PARM_RM-1:0]           Rounding_mode_o,
    output logic                         Invalid_o,
    output logic                         Rm_illegal_o
);

    localparam int W = PARM_EXP + PARM_MANT + 1;

    typedef struct packed {
        logic                 sign;
        logic [PARM_EXP-1:0]  exp;
        logic [PARM_MANT:0]   mant;
        logic                 den;
        logic                 inf;
        logic                 zero;
        logic                 nan;
    } op_t;

    typedef struct packed {
        op_t  op;
        logic snan;
    } dec_t;

    function automatic dec_t unpack(input logic [W-1:0] x);
        dec_t                 d;
        logic [PARM_EXP-1:0]  e;
        logic [PARM_MANT-1:0] f;
        logic                 ez;
        logic                 eo;
        logic                 fz;
        e  = x[PARM_MANT +: PARM_EXP];
        f  = x[PARM_MANT-1:0];
        ez = (e == '0);
        eo = &e;
        fz = (f == '0);
        d.op.sign = x[W-1];
        d.op.exp  = e;
        d.op.mant = {!ez, f};
        d.op.den  = ez && !fz;
        d.op.zero = ez && fz;
        d.op.inf  = eo && fz;
        d.op.nan  = eo && !fz;
        d.snan    = eo && !fz && !f[PARM_MANT-1];
`ifdef FMA_UNPACK_DAZ_EN
        if (d.op.den) begin
            d.op.den  = 1'b0;
            d.op.zero = 1'b1;
            d.op.mant = '0;
            d.op.exp  = '0;
        end
`endif
        return d;
    endfunction

    logic               s1_v;
    logic [W-1:0]       s1_a;
    logic [W-1:0]       s1_b;
    logic [W-1:0]       s1_c;
    logic [PARM_RM-1:0] s1_rm;

    logic               s2_v;
    op_t                s2_a;
    op_t                s2_b;
    op_t                s2_c;
    logic               s2_sub;
    logic [PARM_RM-1:0] s2_rm;
    logic               s2_inv;
    logic               s2_rmi;

    dec_t da;
    dec_t db;
    dec_t dc;
    logic sub;
    logic bc_inf0;
    logic inv;
    logic rmi;
    logic acc_in;
    logic adv;

    assign Ready_o = !(s1_v && s2_v && !Ready_i);
    assign acc_in  = Valid_i && Ready_o;
    assign adv     = s1_v && (!s2_v || Ready_i);

    // Decode the S1 operands and derive the combined exception flags.
    always_comb begin
        da      = unpack(s1_a);
        db      = unpack(s1_b);
        dc      = unpack(s1_c);
        sub     = da.op.sign ^ db.op.sign ^ dc.op.sign;
        bc_inf0 = (db.op.inf && dc.op.zero) || (db.op.zero && dc.op.inf);
        inv     = da.snan || db.snan || dc.snan || bc_inf0 ||
                  (da.op.inf && (db.op.inf || dc.op.inf) && sub &&
                   !db.op.nan && !dc.op.nan && !bc_inf0);
        rmi     = s1_rm > PARM_RM'(4);
    end

    // S1: capture raw operands on acceptance; empty when moved on to S2.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v  <= 1'b0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_c  <= '0;
            s1_rm <= '0;
        end else if (acc_in) begin
            s1_v  <= 1'b1;
            s1_a  <= A_i;
            s1_b  <= B_i;
            s1_c  <= C_i;
            s1_rm <= Rounding_mode_i;
        end else if (adv) begin
            s1_v  <= 1'b0;
        end
    end

    // S2: hold decoded fields until the consumer takes them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_v   <= 1'b0;
            s2_a   <= '0;
            s2_b   <= '0;
            s2_c   <= '0;
            s2_sub <= 1'b0;
            s2_rm  <= '0;
            s2_inv <= 1'b0;
            s2_rmi <= 1'b0;
        end else if (adv) begin
            s2_v   <= 1'b1;
            s2_a   <= da.op;
            s2_b   <= db.op;
            s2_c   <= dc.op;
            s2_sub <= sub;
            s2_rm  <= s1_rm;
            s2_inv <= inv;
            s2_rmi <= rmi;
        end else if (Ready_i) begin
            s2_v   <= 1'b0;
        end
    end

    assign Valid_o         = s2_v;
    assign A_Sign_o        = s2_a.sign;
    assign A_Exp_raw_o     = s2_a.exp;
    assign A_Mant_o        = s2_a.mant;
    assign A_DeN_o         = s2_a.den;
    assign A_Inf_o         = s2_a.inf;
    assign A_Zero_o        = s2_a.zero;
    assign A_NaN_o         = s2_a.nan;
    assign B_Sign_o        = s2_b.sign;
    assign B_Exp_raw_o     = s2_b.exp;
    assign B_Mant_o        = s2_b.mant;
    assign B_DeN_o         = s2_b.den;
    assign B_Inf_o         = s2_b.inf;
    assign B_Zero_o        = s2_b.zero;
    assign B_NaN_o         = s2_b.nan;
    assign C_Sign_o        = s2_c.sign;
    assign C_Exp_raw_o     = s2_c.exp;
    assign C_Mant_o        = s2_c.mant;
    assign C_DeN_o         = s2_c.den;
    assign C_Inf_o         = s2_c.inf;
    assign C_Zero_o        = s2_c.zero;
    assign C_NaN_o         = s2_c.nan;
    assign Sub_Sign_o      = s2_sub;
    assign Rounding_mode_o = s2_rm;
    assign Invalid_o       = s2_inv;
    assign Rm_illegal_o    = s2_rmi;

endmodule

// File: tb/tb_fma_operand_unpack.sv
// Directed self-checking bench for fma_operand_unpack.
// Expected values are hand-computed from the IEEE-754 single encodings.
module tb_fma_operand_unpack;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        Valid_i;
    logic        Ready_o;
    logic [31:0] A_i;
    logic [31:0] B_i;
    logic [31:0] C_i;
    logic [2:0]  Rounding_mode_i;
    logic        Valid_o;
    logic        Ready_i;
    logic        A_Sign_o, B_Sign_o, C_Sign_o;
    logic [7:0]  A_Exp_raw_o, B_Exp_raw_o, C_Exp_raw_o;
    logic [23:0] A_Mant_o, B_Mant_o, C_Mant_o;
    logic        A_DeN_o, A_Inf_o, A_Zero_o, A_NaN_o;
    logic        B_DeN_o, B_Inf_o, B_Zero_o, B_NaN_o;
    logic        C_DeN_o, C_Inf_o, C_Zero_o, C_NaN_o;
    logic        Sub_Sign_o;
    logic [2:0]  Rounding_mode_o;
    logic        Invalid_o;
    logic        Rm_illegal_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_i = ~clk_i;

    fma_operand_unpack dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .Valid_i(Valid_i), .Ready_o(Ready_o),
        .A_i(A_i), .B_i(B_i), .C_i(C_i),
        .Rounding_mode_i(Rounding_mode_i),
        .Valid_o(Valid_o), .Ready_i(Ready_i),
        .A_Sign_o(A_Sign_o), .A_Exp_raw_o(A_Exp_raw_o),
        .A_Mant_o(A_Mant_o), .A_DeN_o(A_DeN_o),
        .A_Inf_o(A_Inf_o), .A_Zero_o(A_Zero_o), .A_NaN_o(A_NaN_o),
        .B_Sign_o(B_Sign_o), .B_Exp_raw_o(B_Exp_raw_o),
        .B_Mant_o(B_Mant_o), .B_DeN_o(B_DeN_o),
        .B_Inf_o(B_Inf_o), .B_Zero_o(B_Zero_o), .B_NaN_o(B_NaN_o),
        .C_Sign_o(C_Sign_o), .C_Exp_raw_o(C_Exp_raw_o),
        .C_Mant_o(C_Mant_o), .C_DeN_o(C_DeN_o),
        .C_Inf_o(C_Inf_o), .C_Zero_o(C_Zero_o), .C_NaN_o(C_NaN_o),
        .Sub_Sign_o(Sub_Sign_o), .Rounding_mode_o(Rounding_mode_o),
        .Invalid_o(Invalid_o), .Rm_illegal_o(Rm_illegal_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One set with Ready_i=1; returns with its result on the outputs.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [2:0] rm);
        Valid_i = 1'b1;
        A_i = a;
        B_i = b;
        C_i = c;
        Rounding_mode_i = rm;
        tick();
        Valid_i = 1'b0;
        check("lat1_valid", 32'(Valid_o), 32'd0);
        tick();
        check("lat2_valid", 32'(Valid_o), 32'd1);
    endtask

    logic [7:0] got_q[$];
    int         sent;
    logic       acc;
    logic [7:0] hold_exp;

    initial begin
        rst_i = 1'b1;
        Valid_i = 1'b0;
        Ready_i = 1'b1;
        A_i = '0;
        B_i = '0;
        C_i = '0;
        Rounding_mode_i = '0;
        tick();
        tick();
        check("rst_valid", 32'(Valid_o), 32'd0);
        check("rst_exp", 32'(A_Exp_raw_o), 32'd0);
        check("rst_rm", 32'(Rounding_mode_o), 32'd0);
        check("rst_inv", 32'(Invalid_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("rst_ready", 32'(Ready_o), 32'd1);

        // 1.0 + 2.0 * -3.0
        send(32'h3F800000, 32'h40000000, 32'hC0400000, 3'd0);
        check("n_aexp", 32'(A_Exp_raw_o), 32'h7F);
        check("n_amant", 32'(A_Mant_o), 32'h800000);
        check("n_bexp", 32'(B_Exp_raw_o), 32'h80);
        check("n_csign", 32'(C_Sign_o), 32'd1);
        check("n_sub", 32'(Sub_Sign_o), 32'd1);
        check("n_inv", 32'(Invalid_o), 32'd0);

        // smallest subnormal
        send(32'h00000001, 32'h3F800000, 32'h3F800000, 3'd0);
`ifdef FMA_UNPACK_DAZ_EN
        check("daz_den", 32'(A_DeN_o), 32'd0);
        check("daz_zero", 32'(A_Zero_o), 32'd1);
        check("daz_mant", 32'(A_Mant_o), 32'd0);
`else
        check("den_den", 32'(A_DeN_o), 32'd1);
        check("den_zero", 32'(A_Zero_o), 32'd0);
        check("den_mant", 32'(A_Mant_o), 32'h000001);
`endif
        check("den_exp", 32'(A_Exp_raw_o), 32'd0);

        // inf * 0
        send(32'h00000000, 32'h7F800000, 32'h00000000, 3'd0);
        check("i0_binf", 32'(B_Inf_o), 32'd1);
        check("i0_czero", 32'(C_Zero_o), 32'd1);
        check("i0_inv", 32'(Invalid_o), 32'd1);

        // signaling NaN in A
        send(32'h7FA00000, 32'h3F800000, 32'h3F800000, 3'd0);
        check("snan_nan", 32'(A_NaN_o), 32'd1);
        check("snan_inv", 32'(Invalid_o), 32'd1);

        // quiet NaN in A
        send(32'h7FC00000, 32'h3F800000, 32'h3F800000, 3'd0);
        check("qnan_nan", 32'(A_NaN_o), 32'd1);
        check("qnan_mant", 32'(A_Mant_o), 32'hC00000);
        check("qnan_inv", 32'(Invalid_o), 32'd0);

        // +inf + (+inf * -1.0): inf - inf
        send(32'h7F800000, 32'h7F800000, 32'hBF800000, 3'd0);
        check("imi_ainf", 32'(A_Inf_o), 32'd1);
        check("imi_inv", 32'(Invalid_o), 32'd1);

        // +inf + (+inf * +1.0): fine
        send(32'h7F800000, 32'h7F800000, 32'h3F800000, 3'd0);
        check("ipi_inv", 32'(Invalid_o), 32'd0);

        // rounding modes at the legality boundary
        send(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b101);
        check("rm5_ill", 32'(Rm_illegal_o), 32'd1);
        check("rm5_pass", 32'(Rounding_mode_o), 32'd5);
        send(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b100);
        check("rm4_ill", 32'(Rm_illegal_o), 32'd0);
        check("rm4_pass", 32'(Rounding_mode_o), 32'd4);

        // drain, then back-pressure with 4 back-to-back sets
        tick();
        Ready_i = 1'b0;
        sent = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            Valid_i = (sent < 4);
            A_i = {1'b0, 8'(10 + sent), 23'(sent)};
            B_i = 32'h3F800000;
            C_i = 32'h3F800000;
            Rounding_mode_i = 3'd0;
            #1;
            acc = Valid_i && Ready_o;
            if (cyc == 4) hold_exp = A_Exp_raw_o;
            tick();
            if (acc) sent++;
        end
        check("bp_sent", 32'(sent), 32'd2);
        check("bp_ready", 32'(Ready_o), 32'd0);
        check("bp_valid", 32'(Valid_o), 32'd1);
        check("bp_hold", 32'(A_Exp_raw_o), 32'(hold_exp));
        check("bp_head", 32'(A_Exp_raw_o), 32'd10);

        Ready_i = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            Valid_i = (sent < 4);
            A_i = {1'b0, 8'(10 + sent), 23'(sent)};
            #1;
            acc = Valid_i && Ready_o;
            if (Valid_o && Ready_i) got_q.push_back(A_Exp_raw_o);
            tick();
            if (acc) sent++;
        end
        Valid_i = 1'b0;
        check("bp_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size())
                check($sformatf("bp_order%0d", i), 32'(got_q[i]),
                      32'(10 + i));

        // reset with two sets in flight
        Ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            Valid_i = 1'b1;
            A_i = 32'h40400000;
            tick();
        end
        check("rf_full", 32'(Valid_o), 32'd1);
        rst_i = 1'b1;
        A_i = 32'h40800000;
        tick();
        rst_i = 1'b0;
        Valid_i = 1'b0;
        Ready_i = 1'b1;
        check("rf_valid", 32'(Valid_o), 32'd0);
        check("rf_ready", 32'(Ready_o), 32'd1);
        check("rf_exp", 32'(A_Exp_raw_o), 32'd0);
        sent = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (Valid_o) sent++;
            tick();
        end
        check("rf_stale", 32'(sent), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
